hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Producer side of the EX-stage forwarding path. It keeps a shadow pipeline of destination register and write-enable for EX, MEM and WB, and drives MEM_Rd, MEM_RegWrite, WB_Rd and WB_RegWrite to the forwarding logic.
- It also detects hazards that forwarding cannot resolve: load-use, taken branch and data-memory wait. For these it drives the stall, flush and bubble controls of the pipeline registers.
- It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MAX_WAIT, 15: memory-wait cycles before Mem_Timeout asserts.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ID_Rs1  input  5  source register 1 of the instruction in ID.
- ID_Rs2  input  5  source register 2 of the instruction in ID.
- ID_UseRs1  input  1  ID instruction reads Rs1.
- ID_UseRs2  input  1  ID instruction reads Rs2.
- ID_Rd  input  5  destination register of the ID instruction.
- ID_RegWrite  input  1  ID instruction writes Rd.
- ID_MemRead  input  1  ID instruction is a load.
- ID_MemAccess  input  1  ID instruction is a load or a store.
- EX_BranchTaken  input  1  EX resolves a taken branch or jump this cycle.
- Mem_Ready  input  1  data memory completes the MEM-stage access this cycle.
- MEM_Rd  output  5  destination register in MEM, to forwarding.
- MEM_RegWrite  output  1  MEM instruction writes Rd.
- WB_Rd  output  5  destination register in WB.
- WB_RegWrite  output  1  WB instruction writes Rd.
- PC_Write  output  1  PC may update.
- IFID_Write  output  1  IF/ID may load.
- IFID_Flush  output  1  IF/ID loads a NOP.
- IDEX_Bubble  output  1  ID/EX loads a NOP.
- Pipe_Freeze  output  1  ID/EX and EX/MEM hold; MEM/WB loads a NOP.
- Mem_Timeout  output  1  sticky: memory wait reached MAX_WAIT.
- Stall_Count  output  CNT_W  saturating count of cycles with PC_Write=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - EX, MEM and WB shadow entries clear: Rd=0, RegWrite=0, MemRead=0, MemAccess=0.
  - FSM goes to RUN. Wait counter = 0, Mem_Timeout = 0, Stall_Count = 0.
  - Outputs during reset: PC_Write=1, IFID_Write=1, all other controls 0.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when the EX entry has MemAccess=1 and it advances into MEM, i.e. a memory op enters MEM.
  - MEM_WAIT -> RUN on a cycle with Mem_Ready=1.
  - MEM_WAIT with Mem_Ready=0 stays in MEM_WAIT.
  - A single-cycle memory therefore sees Mem_Ready=1 on its first MEM cycle and causes no freeze.
- Freeze condition: state=MEM_WAIT and Mem_Ready=0. This has top priority.
  - Outputs: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0.
  - Wait counter increments. When it reaches MAX_WAIT, Mem_Timeout sets and stays set until reset; the freeze continues.
- Branch (no freeze, EX_BranchTaken=1):
  - IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, IFID_Write=1.
  - A load-use hazard in the same cycle is discarded, because the ID instruction is flushed.
- Load-use (no freeze, no branch): EX entry has MemRead=1, EX Rd≠0, and Rd matches (ID_UseRs1 and ID_Rs1) or (ID_UseRs2 and ID_Rs2).
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - Lasts exactly one cycle, because the load moves to MEM and the bubble occupies EX.
- Otherwise: PC_Write=1, IFID_Write=1, all other controls 0.
- All control outputs are combinational from current state and inputs. The shadow entries and FSM are registered.
- Shadow advance on every clock edge:
  - Freeze: EX and MEM hold; WB clears (bubble).
  - No freeze: WB <= MEM; MEM <= EX; EX <= 0 if IDEX_Bubble, else the ID_* fields.
- Rd=0 with RegWrite=1 is stored as given. Forwarding ignores x0, so this unit does not filter it.
- Stall_Count increments on every cycle with PC_Write=0 and saturates at all-ones.

Decomposition:
- Shared pipeline package holds:
  - REG_W=5.
  - The shadow-entry struct (Rd, RegWrite, MemRead, MemAccess) and its NOP constant.
  - State encodings RUN and MEM_WAIT.
- One natural sub-module, hazard_mem_wait_fsm: owns the state, the wait counter and Mem_Timeout.

Test Plan:
- Load-use: load writing x5 enters EX while ID reads x5 with ID_UseRs1=1.
  - Required: one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - Next cycle MEM_Rd=5, MEM_RegWrite=1. Two cycles later WB_Rd=5. Stall_Count=1.
- Same load, but ID reads x5 with ID_UseRs1=0 and ID_UseRs2=0, or ID reads x0 after a load to x0: no stall.
- Branch and load-use together: EX_BranchTaken=1 while a load-use condition holds.
  - Required: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1. Stall_Count unchanged.
- Memory wait: store enters MEM, Mem_Ready held 0 for 3 cycles, then 1.
  - Required: Pipe_Freeze=1 for exactly 3 cycles, with MEM_Rd stable and WB_RegWrite=0.
  - Stall_Count +3. Returns to RUN.
- Timeout: Mem_Ready held 0 for 16 cycles with MAX_WAIT=15.
  - Required: Mem_Timeout rises after the 15th wait cycle and stays 1 after Mem_Ready=1.
- Reset during MEM_WAIT: drop rst_n asynchronously mid-clock.
  - Required: immediate PC_Write=1, Pipe_Freeze=0, MEM_RegWrite=0, WB_RegWrite=0, Stall_Count=0, Mem_Timeout=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline types for the hazard/forwarding producer: shadow entry, NOP, wait-FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_ctrl_unit_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_access;
    } shadow_t;

    localparam shadow_t SHADOW_NOP = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wait_state_t;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks an outstanding MEM-stage data access and raises freeze while memory is not ready.
// Latency: freeze is combinational from state and mem_ready; timeout registers one cycle after the limit.
// Backpressure: freeze holds the whole pipeline; timeout is sticky until reset.
module hazard_mem_wait_fsm
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_mem_access,
    input  logic mem_ready,
    output logic freeze,
    output logic mem_timeout
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    wait_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              mem_enter;

    assign freeze      = (state_q == MEM_WAIT) && !mem_ready;
    // a memory op in EX only moves into MEM when the pipe is not frozen
    assign mem_enter   = ex_mem_access && !freeze;
    assign mem_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_enter) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
                end else begin
                    // a back-to-back memory op re-arms the wait immediately
                    state_d = mem_enter ? MEM_WAIT : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Shadows EX/MEM/WB dest-reg info for forwarding and drives stall/flush/bubble/freeze controls.
// Latency: controls are combinational from current state and inputs; shadow entries register each edge.
// Backpressure: memory wait freezes the pipe (top priority); load-use stalls IF/ID for one cycle.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_Rs1,
    input  logic [REG_W-1:0] ID_Rs2,
    input  logic             ID_UseRs1,
    input  logic             ID_UseRs2,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemAccess,
    input  logic             EX_BranchTaken,
    input  logic             Mem_Ready,
    output logic [REG_W-1:0] MEM_Rd,
    output logic             MEM_RegWrite,
    output logic [REG_W-1:0] WB_Rd,
    output logic             WB_RegWrite,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Pipe_Freeze,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count
);

    shadow_t          ex_q, mem_q, wb_q, id_entry;
    logic             freeze;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q;

    hazard_mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_mem_access (ex_q.mem_access),
        .mem_ready     (Mem_Ready),
        .freeze        (freeze),
        .mem_timeout   (Mem_Timeout)
    );

    assign id_entry = '{rd: ID_Rd, reg_write: ID_RegWrite, mem_read: ID_MemRead,
                        mem_access: ID_MemAccess};

    assign load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                      ((ID_UseRs1 && (ID_Rs1 == ex_q.rd)) ||
                       (ID_UseRs2 && (ID_Rs2 == ex_q.rd)));

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Pipe_Freeze = 1'b0;
        if (!rst_n) begin
            PC_Write = 1'b1;
        end else if (freeze) begin
            Pipe_Freeze = 1'b1;
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
        end else if (EX_BranchTaken) begin
            // the ID instruction is flushed, so any load-use against it is moot
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SHADOW_NOP;
            mem_q <= SHADOW_NOP;
            wb_q  <= SHADOW_NOP;
        end else if (freeze) begin
            wb_q <= SHADOW_NOP;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= IDEX_Bubble ? SHADOW_NOP : id_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!PC_Write && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign MEM_Rd       = mem_q.rd;
    assign MEM_RegWrite = mem_q.reg_write;
    assign WB_Rd        = wb_q.rd;
    assign WB_RegWrite  = wb_q.reg_write;
    assign Stall_Count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: per-cycle expected vectors via a scoreboard queue.
// Latency: expectations are sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_Rs1, ID_Rs2, ID_Rd;
    logic       ID_UseRs1, ID_UseRs2, ID_RegWrite, ID_MemRead, ID_MemAccess;
    logic       EX_BranchTaken, Mem_Ready;
    logic [4:0] MEM_Rd, WB_Rd;
    logic       MEM_RegWrite, WB_RegWrite;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, Mem_Timeout;
    logic [15:0] Stall_Count;

    hazard_ctrl_unit #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UseRs1(ID_UseRs1), .ID_UseRs2(ID_UseRs2),
        .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemAccess(ID_MemAccess), .EX_BranchTaken(EX_BranchTaken), .Mem_Ready(Mem_Ready),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Pipe_Freeze(Pipe_Freeze), .Mem_Timeout(Mem_Timeout),
        .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, ma, br, rdy;
    } stim_t;

    // val/mask layout: {PC_Write,IFID_Write,IFID_Flush,IDEX_Bubble,Pipe_Freeze, MEM_Rd, MEM_RegWrite,
    //                   WB_Rd, WB_RegWrite, Mem_Timeout, Stall_Count}
    typedef struct packed {
        logic [33:0] val;
        logic [33:0] mask;
    } exp_t;

    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] LU   = 5'b00010;
    localparam logic [4:0] BR   = 5'b11110;
    localparam logic [4:0] FRZ  = 5'b00001;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;

    function automatic logic [33:0] act();
        return {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, MEM_Rd, MEM_RegWrite,
                WB_Rd, WB_RegWrite, Mem_Timeout, Stall_Count};
    endfunction

    function automatic exp_t mk(input logic [4:0] ctl, input logic tmo,
                                input logic cm, input logic [4:0] mrd, input logic mrw,
                                input logic cw, input logic [4:0] wrd, input logic wrw);
        exp_t e;
        e.val  = {ctl, mrd, mrw, wrd, wrw, tmo, 16'h0000};
        e.mask = {5'h1f, {6{cm}}, {6{cw}}, 1'b1, 16'hffff};
        return e;
    endfunction

    function automatic exp_t mkc(input logic [4:0] ctl, input logic tmo);
        return mk(ctl, tmo, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction

    function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic [4:0] rd, input logic rw,
                                 input logic mr, input logic ma, input logic br, input logic rdy);
        return '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, rw: rw, mr: mr, ma: ma, br: br, rdy: rdy};
    endfunction

    function automatic stim_t nop(input logic rdy);
        return st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endfunction

    task automatic drive(input stim_t s);
        ID_Rs1 = s.rs1; ID_Rs2 = s.rs2; ID_UseRs1 = s.u1; ID_UseRs2 = s.u2;
        ID_Rd = s.rd; ID_RegWrite = s.rw; ID_MemRead = s.mr; ID_MemAccess = s.ma;
        EX_BranchTaken = s.br; Mem_Ready = s.rdy;
    endtask

    task automatic push_exp(input exp_t e);
        exp_t e2;
        e2 = e;
        e2.val[15:0] = exp_stall[15:0];
        sb.push_back(e2);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(nop(1'b1));
        exp_stall = 0;
        push_exp(mk(NORM, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0));
        #3;
        e = sb.pop_front();
        n_cmp++;
        if ((act() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL reset_state got %h want %h", act() & e.mask, e.val & e.mask);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 5, 1, 1, 1, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(5, 0, 1, 0, 6, 1, 0, 0, 0, 1)); x.push_back(mkc(LU, 0));
        s.push_back(st(5, 0, 1, 0, 6, 1, 0, 0, 0, 1)); x.push_back(mk(NORM, 0, 1, 5, 1, 0, 0, 0));
        s.push_back(nop(1));                           x.push_back(mk(NORM, 0, 1, 0, 0, 1, 5, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL load_use[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_stall();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 5, 1, 1, 1, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(5, 5, 0, 0, 7, 1, 0, 0, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(0, 0, 0, 0, 0, 1, 1, 1, 0, 1)); x.push_back(mk(NORM, 0, 1, 5, 1, 0, 0, 0));
        s.push_back(st(0, 0, 1, 0, 9, 1, 0, 0, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(nop(1));                           x.push_back(mk(NORM, 0, 1, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL no_stall[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_load_use();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 5, 1, 1, 1, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(5, 0, 1, 0, 6, 1, 0, 0, 1, 1)); x.push_back(mkc(BR, 0));
        s.push_back(nop(1));                           x.push_back(mk(NORM, 0, 1, 5, 1, 0, 0, 0));
        s.push_back(nop(1));                           x.push_back(mk(NORM, 0, 1, 0, 0, 1, 5, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL branch_load_use[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 3, 1, 0, 0, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(0, 0, 0, 0, 9, 0, 0, 1, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(st(0, 0, 0, 0, 4, 1, 0, 0, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(nop(0)); x.push_back(mk(FRZ, 0, 1, 9, 0, 1, 3, 1));
        s.push_back(nop(0)); x.push_back(mk(FRZ, 0, 1, 9, 0, 1, 0, 0));
        s.push_back(nop(0)); x.push_back(mk(FRZ, 0, 1, 9, 0, 1, 0, 0));
        s.push_back(nop(1)); x.push_back(mk(NORM, 0, 1, 9, 0, 1, 0, 0));
        s.push_back(nop(0)); x.push_back(mk(NORM, 0, 1, 4, 1, 1, 9, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL mem_wait[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1)); x.push_back(mkc(NORM, 0));
        s.push_back(nop(1));                           x.push_back(mkc(NORM, 0));
        for (int k = 1; k <= 16; k++) begin
            s.push_back(nop(0));
            x.push_back(mkc(FRZ, (k == 16) ? 1'b1 : 1'b0));
        end
        s.push_back(nop(1)); x.push_back(mkc(NORM, 1));
        s.push_back(nop(1)); x.push_back(mkc(NORM, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL timeout[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(st(0, 0, 0, 0, 8, 1, 1, 1, 0, 1)); x.push_back(mkc(NORM, 1));
        s.push_back(nop(1));                           x.push_back(mkc(NORM, 1));
        s.push_back(nop(0)); x.push_back(mk(FRZ, 1, 1, 8, 1, 0, 0, 0));
        s.push_back(nop(0)); x.push_back(mk(FRZ, 1, 1, 8, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ((act() & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL reset_mid_wait[%0d] got %h want %h", i, act() & e.mask, e.val & e.mask);
            end
            if (!e.val[33]) exp_stall++;
            if (i < s.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        // still frozen here; drop reset between clock edges
        #2 rst_n = 1'b0;
        exp_stall = 0;
        push_exp(mk(NORM, 0, 1, 0, 0, 1, 0, 0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ((act() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL reset_async got %h want %h", act() & e.mask, e.val & e.mask);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(nop(0));
        push_exp(mk(NORM, 0, 1, 0, 0, 1, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ((act() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL reset_after_run got %h want %h", act() & e.mask, e.val & e.mask);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
